// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_DATASIZE = 8;
    localparam int DEF_BURSTMAX = 4;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   start,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    // Scan from start upward, wrapping modulo NREQ; first requester found wins.
    always_comb begin
        int c;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        c      = 0;
        for (int i = 0; i < NREQ; i++) begin
            c = (int'(start) + i) % NREQ;
            if (!valid && req[c]) begin
                valid     = 1'b1;
                idx       = PW'(c);
                onehot[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int BURSTMAX = DEF_BURSTMAX
) (
    input  logic                     wclk_i,
    input  logic                     wrst_n_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*DATASIZE-1:0] data_i,
    input  logic [NREQ-1:0]          last_i,
    output logic [NREQ-1:0]          gnt_o,
    input  logic                     fifo_full_i,
    input  logic                     fifo_almost_full_i,
    output logic                     wen_o,
    output logic [DATASIZE-1:0]      wdata_o,
    output logic [ptr_w(NREQ)-1:0]   owner_o,
    output logic                     busy_o
);

    localparam int PW = ptr_w(NREQ);
    localparam int BW = $clog2(BURSTMAX + 1);

    arb_state_t          state, state_nx;
    logic [PW-1:0]       prio_ptr, prio_nx;
    logic [PW-1:0]       owner, owner_nx;
    logic [BW-1:0]       beat_cnt, cnt_nx, cnt_inc;
    logic                ok;
    logic                accept;
    logic [PW-1:0]       acc_idx;
    logic [DATASIZE-1:0] acc_data;
    logic [NREQ-1:0]     pick_onehot;
    logic [PW-1:0]       pick_idx;
    logic                pick_valid;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // An almost-full FIFO can absorb one write, but not one behind a write already in flight.
    assign ok = ~fifo_full_i & ~(fifo_almost_full_i & wen_o);

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req_i),
        .start  (prio_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign cnt_inc = beat_cnt + 1'b1;

    // Grant decode, burst accounting and next-state selection.
    always_comb begin
        gnt_o    = '0;
        accept   = 1'b0;
        acc_idx  = owner;
        state_nx = state;
        prio_nx  = prio_ptr;
        owner_nx = owner;
        cnt_nx   = beat_cnt;
        case (state)
            IDLE: begin
                if (ok && pick_valid) begin
                    gnt_o    = pick_onehot;
                    accept   = 1'b1;
                    acc_idx  = pick_idx;
                    owner_nx = pick_idx;
                    if (last_i[pick_idx] || BURSTMAX == 1) begin
                        prio_nx = wrap_inc(pick_idx);
                        cnt_nx  = '0;
                    end else begin
                        state_nx = LOCK;
                        cnt_nx   = BW'(1);
                    end
                end
            end
            LOCK: begin
                // Only the owner may proceed; a stalled owner holds the lock indefinitely.
                if (ok && req_i[owner]) begin
                    gnt_o[owner] = 1'b1;
                    accept       = 1'b1;
                    if (last_i[owner] || cnt_inc == BW'(BURSTMAX)) begin
                        state_nx = IDLE;
                        prio_nx  = wrap_inc(owner);
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Select the accepted requester's data lane.
    always_comb begin
        acc_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (acc_idx == PW'(k)) begin
                acc_data = data_i[k*DATASIZE +: DATASIZE];
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            state    <= IDLE;
            prio_ptr <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            prio_ptr <= prio_nx;
            owner    <= owner_nx;
            beat_cnt <= cnt_nx;
        end
    end

    // Registered FIFO write side; data holds when nothing is written.
    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            wen_o   <= 1'b0;
            wdata_o <= '0;
        end else begin
            wen_o <= accept;
            if (accept) begin
                wdata_o <= acc_data;
            end
        end
    end

    assign owner_o = owner;
    assign busy_o  = (state == LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for the FIFO write-port arbiter
module tb_fifo_wr_arbiter;

    logic        wclk_i = 1'b0;
    logic        wrst_n_i = 1'b0;
    logic [3:0]  req_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  last_i = '0;
    logic [3:0]  gnt_o;
    logic        fifo_full_i = 1'b0;
    logic        fifo_almost_full_i = 1'b0;
    logic        wen_o;
    logic [7:0]  wdata_o;
    logic [1:0]  owner_o;
    logic        busy_o;

    typedef struct {
        logic [7:0] data;
        logic [1:0] own;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    fifo_wr_arbiter #(
        .NREQ     (4),
        .DATASIZE (8),
        .BURSTMAX (4)
    ) dut (
        .wclk_i             (wclk_i),
        .wrst_n_i           (wrst_n_i),
        .req_i              (req_i),
        .data_i             (data_i),
        .last_i             (last_i),
        .gnt_o              (gnt_o),
        .fifo_full_i        (fifo_full_i),
        .fifo_almost_full_i (fifo_almost_full_i),
        .wen_o              (wen_o),
        .wdata_o            (wdata_o),
        .owner_o            (owner_o),
        .busy_o             (busy_o)
    );

    always #5 wclk_i = ~wclk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One cycle: drive after the edge, check grant/busy mid-cycle, queue the expected write.
    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l,
                        input logic f, input logic a, input logic [3:0] eg, input logic eb);
        wr_t e;
        @(posedge wclk_i);
        #1;
        req_i              = r;
        data_i             = d;
        last_i             = l;
        fifo_full_i        = f;
        fifo_almost_full_i = a;
        @(negedge wclk_i);
        check("gnt", 32'(gnt_o), 32'(eg));
        check("busy", 32'(busy_o), 32'(eb));
        for (int k = 0; k < 4; k++) begin
            if (eg[k]) begin
                e.data = d[k*8 +: 8];
                e.own  = 2'(k);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: every write presented to the FIFO must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(posedge wclk_i);
            #3;
            if (wen_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wen at %0t: wdata %0h with nothing expected", $time, wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wdata", 32'(wdata_o), 32'(e.data));
                    check("owner", 32'(owner_o), 32'(e.own));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #8;
        check("rst_wen", 32'(wen_o), 0);
        check("rst_wdata", 32'(wdata_o), 0);
        check("rst_owner", 32'(owner_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_gnt", 32'(gnt_o), 0);
        #4 wrst_n_i = 1'b1;

        // single beat from requester 0
        step(4'b0001, 32'h0000_0011, 4'b0001, 0, 0, 4'b0001, 0);

        // all four with single-beat packets: rotation starts at 1
        step(4'b1111, 32'hA3A2_A1A0, 4'b1111, 0, 0, 4'b0010, 0);
        step(4'b1111, 32'hB3B2_B1B0, 4'b1111, 0, 0, 4'b0100, 0);
        step(4'b1111, 32'hC3C2_C1C0, 4'b1111, 0, 0, 4'b1000, 0);
        step(4'b1111, 32'hD3D2_D1D0, 4'b1111, 0, 0, 4'b0001, 0);
        step(4'b1111, 32'hE3E2_E1E0, 4'b1111, 0, 0, 4'b0010, 0);

        // 6-beat packet from 2 is cut at 4 beats, 3 gets a turn, 2 resumes
        step(4'b1100, 32'h3121_0000, 4'b1000, 0, 0, 4'b0100, 0);
        step(4'b1100, 32'h3122_0000, 4'b1000, 0, 0, 4'b0100, 1);
        step(4'b1100, 32'h3123_0000, 4'b1000, 0, 0, 4'b0100, 1);
        step(4'b1100, 32'h3124_0000, 4'b1000, 0, 0, 4'b0100, 1);
        step(4'b1100, 32'h3125_0000, 4'b1000, 0, 0, 4'b1000, 0);
        step(4'b0100, 32'h0025_0000, 4'b0000, 0, 0, 4'b0100, 0);
        step(4'b0100, 32'h0026_0000, 4'b0100, 0, 0, 4'b0100, 1);

        // almost-full: grants alternate with writes in flight; full blocks everything
        step(4'b0001, 32'h0000_0040, 4'b0001, 0, 1, 4'b0000, 0);
        step(4'b0001, 32'h0000_0041, 4'b0001, 0, 1, 4'b0001, 0);
        step(4'b0001, 32'h0000_0042, 4'b0001, 0, 1, 4'b0000, 0);
        step(4'b0001, 32'h0000_0043, 4'b0001, 0, 1, 4'b0001, 0);
        step(4'b0001, 32'h0000_0050, 4'b0001, 1, 0, 4'b0000, 0);
        step(4'b0001, 32'h0000_0051, 4'b0001, 1, 0, 4'b0000, 0);
        step(4'b0001, 32'h0000_0052, 4'b0001, 1, 1, 4'b0000, 0);
        step(4'b0001, 32'h0000_0053, 4'b0001, 0, 0, 4'b0001, 0);

        // owner 1 stalls for three cycles while 0 waits
        step(4'b0011, 32'h0000_6160, 4'b0000, 0, 0, 4'b0010, 0);
        step(4'b0001, 32'h0000_0060, 4'b0001, 0, 0, 4'b0000, 1);
        step(4'b0001, 32'h0000_0060, 4'b0001, 0, 0, 4'b0000, 1);
        step(4'b0001, 32'h0000_0060, 4'b0001, 0, 0, 4'b0000, 1);
        step(4'b0011, 32'h0000_6260, 4'b0010, 0, 0, 4'b0010, 1);
        step(4'b0001, 32'h0000_0063, 4'b0001, 0, 0, 4'b0001, 0);

        // reset in the middle of a burst from 1
        step(4'b0110, 32'h0000_7100, 4'b0000, 0, 0, 4'b0010, 0);
        step(4'b0110, 32'h0000_7200, 4'b0000, 0, 0, 4'b0010, 1);
        @(posedge wclk_i);
        #1;
        req_i = '0;
        #4;
        wrst_n_i = 1'b0;
        #1;
        check("mid_rst_wen", 32'(wen_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_owner", 32'(owner_o), 0);
        @(posedge wclk_i);
        #4 wrst_n_i = 1'b1;
        step(4'b0101, 32'h0082_0080, 4'b0101, 0, 0, 4'b0001, 0);
        step(4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 4'b0000, 0);

        repeat (3) @(posedge wclk_i);
        #5;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the write clock domain. It accepts bursts (packets) from one requester at a time, drives the FIFO write enable and data from registers, and throttles on the FIFO's registered full and almost-full flags so that no write is ever issued into a full FIFO. It sits between the requester logic and the FIFO's write-pointer/memory write side.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATASIZE, 8, FIFO data width
- BURSTMAX, 4, maximum beats per grant before forced rotation (1..16)
- wclk_i  in  1  write clock
- wrst_n_i  in  1  reset, asynchronous, active-low
- req_i  in  NREQ  per-requester valid; data_i/last_i qualified by it
- data_i  in  NREQ*DATASIZE  flattened data, requester k at [k*DATASIZE +: DATASIZE]
- last_i  in  NREQ  final beat of a packet
- gnt_o  out  NREQ  one-hot ready; beat from k accepted when req_i[k] & gnt_o[k]
- fifo_full_i  in  1  FIFO full flag (registered, write domain)
- fifo_almost_full_i  in  1  FIFO almost-full flag (registered, write domain)
- wen_o  out  1  FIFO write enable (registered)
- wdata_o  out  DATASIZE  FIFO write data (registered)
- owner_o  out  $clog2(NREQ)  index of current/last grant owner
- busy_o  out  1  high while in LOCK

## Operation
- FSM states: IDLE, LOCK.
- Issue permission ok = ~fifo_full_i & ~(fifo_almost_full_i & wen_o). gnt_o is all-zero whenever ok=0.
- IDLE: if ok and any req_i, pick first requester at or after prio_ptr (wrapping); assert gnt_o for it combinationally, accept beat, owner <= k, beat_cnt <= 1. If that beat has last_i=1 or BURSTMAX=1: stay IDLE, prio_ptr <= (k+1) mod NREQ. Else -> LOCK.
- LOCK: gnt_o only to owner, only when ok & req_i[owner]. Other requests ignored. Each accepted beat increments beat_cnt. Burst ends on accepted beat with last_i=1 or beat_cnt+1==BURSTMAX: -> IDLE, prio_ptr <= (owner+1) mod NREQ, beat_cnt <= 0.
- Owner dropping req_i in LOCK: arbiter holds LOCK, no grant, no timeout.
- Accepted beat: next cycle wen_o=1, wdata_o=data of accepted beat; otherwise wen_o=0, wdata_o holds.
- beat_cnt width $clog2(BURSTMAX+1); prio_ptr/owner wrap modulo NREQ (non-power-of-2 NREQ legal).

## Timing
- Reset values: wen_o=0, wdata_o=0, owner_o=0, busy_o=0, gnt_o=0 (combinational, forced by state IDLE with prio_ptr=0 only when no req), state IDLE, prio_ptr=0, beat_cnt=0.
- gnt_o combinational from req_i, state, flags; wen_o/wdata_o one cycle after acceptance.
- Back-to-back acceptance every cycle while ok holds; IDLE->new owner possible in the cycle after a burst ends (no bubble).
- Full/almost-full: with almost_full=1 and a write in flight, no grant that cycle; at most one write per cycle while almost_full, none while full.
- Reset mid-burst: all state cleared immediately; partial packet is abandoned (requester must resend).

## Structure
- Package fifo_arb_pkg: state enum {IDLE, LOCK}, default NREQ/DATASIZE/BURSTMAX constants, ptr-width function.
- Sub-module rr_pick: combinational round-robin picker (req vector, start pointer -> one-hot + index, valid).
- Top contains FSM, counters, output registers.

## Test plan
- Reset then req_i=4'b0001, data 0x11, last=1 -> gnt_o=0001 same cycle; next cycle wen_o=1, wdata_o=0x11; prio_ptr=1.
- All four requesting single-beat packets continuously, FIFO empty -> grant order 0,1,2,3,0 with wen_o high every cycle.
- Requester 2 sends 6-beat packet, BURSTMAX=4, requester 3 waiting -> 4 beats from 2, then 3 granted, then 2 resumes later.
- fifo_almost_full_i=1 with wen_o=1 -> gnt_o=0 that cycle; fifo_full_i=1 -> no grants until it drops; no wen_o while full.
- Owner 1 drops req_i mid-packet for 3 cycles while requester 0 requests -> busy_o=1, gnt_o=0 throughout, requester 1 resumes on return.
- wrst_n_i pulsed low mid-burst -> wen_o=0, busy_o=0, owner_o=0 immediately; after release requester 0 wins first.
